// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// States, access-size codes and the default memory timeout.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering: byte enables, store replication, load extraction.
// Purely combinational; legality and alignment are decoded here too.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] load_word,
   output logic [3:0]            be,
   output logic [DATA_WIDTH-1:0] store_lanes,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  legal,
   output logic                  misaligned
);

   logic [7:0]  lb;
   logic [15:0] lh;

   assign lb = load_word[{offset, 3'b000} +: 8];
   assign lh = load_word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      be          = 4'b0000;
      store_lanes = '0;
      load_data   = '0;
      legal       = 1'b1;
      misaligned  = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            be          = 4'b0001 << offset;
            store_lanes = {(DATA_WIDTH/8){store_data[7:0]}};
            load_data   = (funct3 == F3_B)
                        ? {{(DATA_WIDTH-8){lb[7]}}, lb}
                        : {{(DATA_WIDTH-8){1'b0}}, lb};
         end
         F3_H, F3_HU: begin
            be          = 4'b0011 << {offset[1], 1'b0};
            store_lanes = {(DATA_WIDTH/16){store_data[15:0]}};
            load_data   = (funct3 == F3_H)
                        ? {{(DATA_WIDTH-16){lh[15]}}, lh}
                        : {{(DATA_WIDTH-16){1'b0}}, lh};
            misaligned  = offset[0];
         end
         F3_W: begin
            be          = 4'b1111;
            store_lanes = store_data;
            load_data   = load_word;
            misaligned  = (offset != 2'b00);
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus access per request,
// stalling the pipeline until ack or timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     MemReadM,
   input  logic                     MemWriteM,
   input  logic [2:0]               Funct3M,
   input  logic [ADDRESS_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0]    WriteDataM,
   output logic [DATA_WIDTH-1:0]    ReadDataM,
   output logic                     StallM,
   output logic                     AccessErrM,
   output logic                     BusErrM,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [3:0]               mem_be,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ack
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic            load_q;

   logic            req;
   logic            ok;
   logic [2:0]      sel_f3;
   logic [1:0]      sel_off;
   logic [3:0]      be;
   logic [DATA_WIDTH-1:0] lanes;
   logic [DATA_WIDTH-1:0] ldata;
   logic            legal;
   logic            misaligned;

   // Decoder sees the live request in IDLE, the latched one afterwards
   assign sel_f3  = (state == S_IDLE) ? Funct3M : f3_q;
   assign sel_off = (state == S_IDLE) ? ALUResultM[1:0] : off_q;

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .funct3      (sel_f3),
      .offset      (sel_off),
      .store_data  (WriteDataM),
      .load_word   (mem_rdata),
      .be          (be),
      .store_lanes (lanes),
      .load_data   (ldata),
      .legal       (legal),
      .misaligned  (misaligned)
   );

   assign req    = MemReadM | MemWriteM;
   assign ok     = req & legal & ~misaligned;
   assign StallM = rst & (((state == S_IDLE) & ok) | (state == S_WAIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         load_q     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         ReadDataM  <= '0;
         AccessErrM <= 1'b0;
         BusErrM    <= 1'b0;
      end else begin
         AccessErrM <= 1'b0;
         BusErrM    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req && ok) begin
                  mem_req   <= 1'b1;
                  mem_we    <= MemWriteM;
                  mem_addr  <= {ALUResultM[ADDRESS_WIDTH-1:2], 2'b00};
                  mem_be    <= be;
                  mem_wdata <= lanes;
                  f3_q      <= Funct3M;
                  off_q     <= ALUResultM[1:0];
                  load_q    <= ~MemWriteM;
                  cnt       <= '0;
                  state     <= S_WAIT;
               end else if (req) begin
                  AccessErrM <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (load_q) ReadDataM <= ldata;
                  state   <= S_DONE;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  BusErrM   <= 1'b1;
                  ReadDataM <= '0;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
// Inputs change 1ns after a rising edge; checks follow 1ns later.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM, AccessErrM, BusErrM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;
   int stall_n = 0;
   int rises = 0;
   int snap;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .AccessErrM (AccessErrM),
      .BusErrM    (BusErrM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always @(negedge clk) begin
      if (StallM) stall_n++;
      if (mem_req && !req_prev) rises++;
      req_prev = mem_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      Funct3M   = 3'b000;
      ALUResultM = 32'h0;
      WriteDataM = 32'h0;
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      mem_rdata = 32'h0;
      mem_ack = 1'b0;
      tick();
      tick();
      chk("rst_req", mem_req, 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      MemReadM = 1'b1;
      #1;
      chk("rst_stall", StallM, 0);
      idle_in();
      rst = 1'b1;
      tick();

      // LB at 0x102, ack in first WAIT cycle
      stall_n = 0;
      MemReadM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h102;
      #1;
      chk("lb_stall_idle", StallM, 1);
      tick();
      chk("lb_req", mem_req, 1);
      chk("lb_addr", mem_addr, 32'h100);
      chk("lb_we", mem_we, 0);
      mem_rdata = 32'h80FF7F01; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("lb_data", ReadDataM, 32'hFFFFFFFF);
      chk("lb_done_req", mem_req, 0);
      chk("lb_done_stall", StallM, 0);
      idle_in();
      tick();
      chk("lb_stall_cycles", stall_n, 2);

      // SH 0x1234ABCD at 0x202, ack after one extra cycle
      snap = rises;
      MemWriteM = 1'b1; Funct3M = 3'b001;
      ALUResultM = 32'h202; WriteDataM = 32'h1234ABCD;
      tick();
      chk("sh_be", mem_be, 4'b1100);
      chk("sh_wdata", mem_wdata, 32'hABCDABCD);
      chk("sh_we", mem_we, 1);
      chk("sh_addr", mem_addr, 32'h200);
      tick();
      chk("sh_hold_req", mem_req, 1);
      chk("sh_hold_be", mem_be, 4'b1100);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      idle_in();
      chk("sh_done_req", mem_req, 0);
      chk("sh_rdata_kept", ReadDataM, 32'hFFFFFFFF);
      tick();
      chk("sh_episodes", rises - snap, 1);

      // LW misaligned at 0x301
      snap = rises;
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h301;
      #1;
      chk("lw_mis_stall", StallM, 0);
      tick();
      idle_in();
      chk("lw_mis_err", AccessErrM, 1);
      chk("lw_mis_req", mem_req, 0);
      tick();
      chk("lw_mis_pulse", AccessErrM, 0);
      chk("lw_mis_noreq", rises - snap, 0);

      // Illegal funct3
      MemReadM = 1'b1; Funct3M = 3'b011; ALUResultM = 32'h0;
      tick();
      idle_in();
      chk("ill_err", AccessErrM, 1);
      chk("ill_req", mem_req, 0);
      tick();

      // LHU at 0x400, ack withheld -> timeout
      MemReadM = 1'b1; Funct3M = 3'b101; ALUResultM = 32'h400;
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_wait_req", mem_req, 1);
         chk("to_wait_berr", BusErrM, 0);
      end
      tick();
      idle_in();
      chk("to_berr", BusErrM, 1);
      chk("to_req", mem_req, 0);
      chk("to_rdata", ReadDataM, 0);
      chk("to_stall", StallM, 0);
      tick();
      chk("to_berr_pulse", BusErrM, 0);

      // ack while idle is ignored
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_req", mem_req, 0);
      chk("idle_ack_stall", StallM, 0);

      // reset during WAIT of a slow load
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500;
      tick();
      tick();
      chk("mid_req", mem_req, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_stall", StallM, 0);
      chk("mid_rst_addr", mem_addr, 0);
      idle_in();
      tick();
      rst = 1'b1;
      MemReadM = 1'b1; Funct3M = 3'b100; ALUResultM = 32'h003;
      tick();
      chk("lbu_req", mem_req, 1);
      chk("lbu_addr", mem_addr, 32'h0);
      mem_rdata = 32'h9A000000; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      idle_in();
      chk("lbu_data", ReadDataM, 32'h0000009A);
      tick();

      // both strobes high -> store
      MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b010;
      ALUResultM = 32'h10; WriteDataM = 32'hDEADBEEF;
      tick();
      chk("both_we", mem_we, 1);
      chk("both_be", mem_be, 4'b1111);
      chk("both_wdata", mem_wdata, 32'hDEADBEEF);
      chk("both_addr", mem_addr, 32'h10);
      mem_rdata = 32'h11111111; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      idle_in();
      chk("both_rdata_kept", ReadDataM, 32'h0000009A);
      tick();
      chk("both_idle_req", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH SHALL default to 32 and set the byte-address width.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the memory word width (bus assumes 4 byte lanes).
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 16 and set the maximum wait for mem_ack.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 MemReadM  in  1  memory-stage load request.
REQ-007 MemWriteM  in  1  memory-stage store request.
REQ-008 Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ALUResultM  in  ADDRESS_WIDTH  byte address.
REQ-010 WriteDataM  in  DATA_WIDTH  store data, right-aligned.
REQ-011 ReadDataM  out  DATA_WIDTH  registered, aligned, extended load data.
REQ-012 StallM  out  1  holds all pipeline stages while high.
REQ-013 AccessErrM  out  1  one-cycle pulse: misaligned address or illegal Funct3M.
REQ-014 BusErrM  out  1  one-cycle pulse: memory timeout.
REQ-015 mem_req, mem_we  out  1 each  registered bus request and write qualifier.
REQ-016 mem_addr  out  ADDRESS_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-017 mem_be  out  4  byte enables; mem_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-018 mem_rdata  in  DATA_WIDTH; mem_ack  in  1  one-cycle completion strobe.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-020 IDLE: a request is MemReadM or MemWriteM; if both are high, the access SHALL be a store.
REQ-021 IDLE with a legal, aligned request: assert StallM combinationally the same cycle; register mem_addr/mem_be/mem_wdata/mem_we; set mem_req=1; go to WAIT.
REQ-022 Misalignment SHALL be H/HU with addr[0]=1, or W with addr[1:0]!=0; illegal Funct3M is any other code.
REQ-023 A misaligned or illegal request SHALL pulse AccessErrM for one cycle, issue no bus access, keep StallM=0 and stay in IDLE.
REQ-024 WAIT: mem_req and StallM SHALL stay 1 with bus outputs stable until mem_ack=1.
REQ-025 On mem_ack in WAIT: mem_req drops next cycle; loads latch extracted data into ReadDataM; FSM goes to DONE.
REQ-026 A 0-wait memory (mem_ack in the first WAIT cycle) SHALL be accepted; total load latency is then 2 cycles of StallM.
REQ-027 WAIT SHALL count cycles; at TIMEOUT_CYCLES without mem_ack it SHALL drop mem_req, pulse BusErrM, set ReadDataM=0 and go to DONE.
REQ-028 DONE: StallM=0 for exactly one cycle; requests present are not re-issued; next state is IDLE.
REQ-029 mem_ack in IDLE or DONE SHALL be ignored.
REQ-030 Store lanes: B mem_be=0001<<addr[1:0]; H mem_be=0011<<(2*addr[1]); W mem_be=1111; byte/half data replicated across lanes.
REQ-031 Load extraction SHALL select the lane by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-032 ReadDataM SHALL hold its value until the next completed load or timeout.

Reset
REQ-033 rst low SHALL immediately force FSM=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadDataM=0, AccessErrM=0, BusErrM=0, timeout count=0, mid-transaction included.
REQ-034 StallM SHALL be 0 while rst is low; the first request is accepted on the first edge after rst rises.

Structure
REQ-035 Package lsu_pkg SHALL hold the state enum, Funct3 size constants and the default TIMEOUT_CYCLES.
REQ-036 Byte-enable generation, store replication and load extraction SHALL be in one combinational sub-module, lsu_align.
REQ-037 No memory array SHALL live in this block; data_mem attaches to the mem_* port.

Verification
REQ-038 LB at 0x102, mem word 0x80FF7F01, ack after 1 cycle -> ReadDataM=0xFFFFFFFF, mem_addr=0x100, StallM high 2 cycles.
REQ-039 SH 0x1234ABCD at 0x202 -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, single mem_req episode.
REQ-040 LW at 0x301 -> AccessErrM one pulse, mem_req never asserted, StallM=0.
REQ-041 LHU at 0x400, ack withheld -> BusErrM pulse after 16 WAIT cycles, ReadDataM=0, then IDLE.
REQ-042 rst low during WAIT of a 3-cycle load -> mem_req=0 immediately; after release, LBU at 0x003 of 0x9A000000 -> ReadDataM=0x0000009A.
REQ-043 MemReadM and MemWriteM both high, SW 0xDEADBEEF at 0x10 -> store performed, mem_be=1111, ReadDataM unchanged.
